// File: rtl/writeback_queue_if.sv
// rtl/writeback_queue_if.sv - bundle of writeback queue push, drain and lookup signals
//
// Purpose: groups every signal of writeback_queue except clk/reset.
// Ports (slave = queue side):
//   push     : in_valid, in_ready, in_dest, in_data
//   drain    : hold, a3, d3, iswb (register file write port)
//   lookup   : rd_a1, rd_a2 -> fwd_hit1/2, fwd_d1/2
//   status   : count, empty, full
interface writeback_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_dest;
  logic [DW-1:0] in_data;
  logic          hold;
  logic [AW-1:0] a3;
  logic [DW-1:0] d3;
  logic          iswb;
  logic [AW-1:0] rd_a1;
  logic [AW-1:0] rd_a2;
  logic          fwd_hit1;
  logic          fwd_hit2;
  logic [DW-1:0] fwd_d1;
  logic [DW-1:0] fwd_d2;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  modport master (
    output in_valid, in_dest, in_data, hold, rd_a1, rd_a2,
    input  in_ready, a3, d3, iswb, fwd_hit1, fwd_hit2, fwd_d1, fwd_d2,
           count, empty, full
  );

  modport slave (
    input  in_valid, in_dest, in_data, hold, rd_a1, rd_a2,
    output in_ready, a3, d3, iswb, fwd_hit1, fwd_hit2, fwd_d1, fwd_d2,
           count, empty, full
  );
endinterface

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order result queue draining into the register file write port
//
// Purpose: buffers completed results, retires one per cycle to a3/d3/iswb and
// offers decode a combinational lookup of still-pending results.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : asynchronous, active-low
//   bus   : writeback_queue_if.slave (push, drain, lookup and status signals)
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  writeback_queue_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_dest [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  // in_ready is gated by reset so nothing is offered as accepted while the
  // queue is being held in reset.
  assign bus.in_ready = reset && !full;
  assign bus.iswb     = !empty && !bus.hold;
  assign bus.a3       = empty ? '0 : mem_dest[head];
  assign bus.d3       = empty ? '0 : mem_data[head];
  assign bus.count    = count;
  assign bus.empty    = empty;
  assign bus.full     = full;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.iswb;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_dest[i] <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_dest[tail] <= bus.in_dest;
        mem_data[tail] <= bus.in_data;
        tail           <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CW'(DEPTH));
    end
  end

  // Walk occupied slots from oldest (head) to youngest; a later match
  // overwrites an earlier one, so the youngest pending result wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx          = '0;
    bus.fwd_hit1 = 1'b0;
    bus.fwd_hit2 = 1'b0;
    bus.fwd_d1   = '0;
    bus.fwd_d2   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if (mem_dest[idx] == bus.rd_a1) begin
          bus.fwd_hit1 = 1'b1;
          bus.fwd_d1   = mem_data[idx];
        end
        if (mem_dest[idx] == bus.rd_a2) begin
          bus.fwd_hit2 = 1'b1;
          bus.fwd_d2   = mem_data[idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - scoreboard bench for writeback_queue
module tb_writeback_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 4;
  localparam int DW    = 32;

  logic clk;
  logic reset;

  writeback_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic [AW+DW-1:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every register file write must match the oldest expected entry.
  always @(negedge clk) begin
    if (bus.iswb === 1'b1) begin
      logic [AW+DW-1:0] e;
      n_writes++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_write: got a3=%0d d3=0x%08h expected no write", bus.a3, bus.d3);
      end else begin
        e = sb.pop_front();
        check("write_a3", 32'(bus.a3), 32'(e[AW+DW-1:DW]));
        check("write_d3", bus.d3, e[DW-1:0]);
      end
    end
  end

  // Drive one cycle of stimulus at posedge+1, return at the next posedge+1.
  task automatic step(input logic v, input logic [AW-1:0] d, input logic [DW-1:0] x, input logic h);
    bus.in_valid = v;
    bus.in_dest  = d;
    bus.in_data  = x;
    bus.hold     = h;
    #0;
    if (v && bus.in_ready === 1'b1) sb.push_back({d, x});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic h, input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, h);
  endtask

  initial begin
    int w0;
    reset        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_dest  = 4'd3;
    bus.in_data  = 32'h1234_5678;
    bus.hold     = 1'b0;
    bus.rd_a1    = 4'd0;
    bus.rd_a2    = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_iswb", 32'(bus.iswb), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_fwd_hit1", 32'(bus.fwd_hit1), 0);
    check("rst_fwd_d2", bus.fwd_d2, 0);

    bus.in_valid = 1'b0;
    reset        = 1'b1;
    idle(1'b0, 1);
    check("post_rst_in_ready", 32'(bus.in_ready), 1);
    check("post_rst_iswb", 32'(bus.iswb), 0);

    // Single write.
    step(1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0);
    bus.rd_a1 = 4'd5;
    #1;
    check("single_a3", 32'(bus.a3), 5);
    check("single_d3", bus.d3, 32'hDEAD_BEEF);
    check("single_iswb", 32'(bus.iswb), 1);
    check("single_fwd_hit1", 32'(bus.fwd_hit1), 1);
    check("single_fwd_d1", bus.fwd_d1, 32'hDEAD_BEEF);
    idle(1'b0, 1);
    check("single_empty", 32'(bus.empty), 1);
    check("single_iswb_off", 32'(bus.iswb), 0);
    check("single_a3_empty", 32'(bus.a3), 0);

    // Fill under hold, overflow attempt, then drain.
    step(1'b1, 4'd1, 32'h11, 1'b1);
    step(1'b1, 4'd2, 32'h22, 1'b1);
    step(1'b1, 4'd3, 32'h33, 1'b1);
    step(1'b1, 4'd4, 32'h44, 1'b1);
    check("fill_full", 32'(bus.full), 1);
    check("fill_in_ready", 32'(bus.in_ready), 0);
    check("fill_count", 32'(bus.count), 4);
    check("fill_iswb_hold", 32'(bus.iswb), 0);
    step(1'b1, 4'd9, 32'h55, 1'b1);
    check("overflow_count", 32'(bus.count), 4);
    w0 = n_writes;
    idle(1'b0, 4);
    check("fill_drain_writes", 32'(n_writes - w0), 4);
    check("fill_drain_empty", 32'(bus.empty), 1);

    // Forwarding priority: youngest of two same-dest entries wins.
    step(1'b1, 4'd7, 32'h100, 1'b1);
    step(1'b1, 4'd7, 32'h200, 1'b1);
    bus.rd_a1 = 4'd7;
    bus.rd_a2 = 4'd3;
    #1;
    check("fwd_hit1", 32'(bus.fwd_hit1), 1);
    check("fwd_d1_youngest", bus.fwd_d1, 32'h200);
    check("fwd_hit2", 32'(bus.fwd_hit2), 0);
    check("fwd_d2", bus.fwd_d2, 0);
    bus.rd_a2 = 4'd0;
    #1;
    check("fwd_r0_unoccupied", 32'(bus.fwd_hit2), 0);
    idle(1'b0, 3);
    check("fwd_drain_empty", 32'(bus.empty), 1);

    // Continuous pushes across the wrap with hold toggling.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, AW'(i), 32'hA000 + 32'(i), (i % 4) >= 1);
      check("wrap_count_le_depth", 32'(bus.count <= 3'(DEPTH)), 1);
    end
    idle(1'b0, 6);
    check("wrap_empty", 32'(bus.empty), 1);

    // Reset in the middle of a drain.
    step(1'b1, 4'd10, 32'hB0, 1'b1);
    step(1'b1, 4'd11, 32'hB1, 1'b1);
    step(1'b1, 4'd12, 32'hB2, 1'b1);
    check("mid_count", 32'(bus.count), 3);
    idle(1'b0, 1);
    check("mid_iswb_draining", 32'(bus.iswb), 1);
    reset = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_iswb", 32'(bus.iswb), 0);
    check("mid_rst_count", 32'(bus.count), 0);
    check("mid_rst_d3", bus.d3, 0);
    w0 = n_writes;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1'b0, 3);
    check("mid_no_writes", 32'(n_writes - w0), 0);
    check("mid_post_count", 32'(bus.count), 0);
    check("mid_post_empty", 32'(bus.empty), 1);

    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
